// File: rtl/blk_mem_pkg.sv
// Shared constants and helpers for the parametrised block memory controller.
// Holds read-during-write mode codes, FSM encoding and the byte-merge function.
package blk_mem_pkg;

    localparam logic [1:0] WR_FIRST  = 2'd0;
    localparam logic [1:0] RD_FIRST  = 2'd1;
    localparam logic [1:0] NO_CHANGE = 2'd2;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Callers zero-extend to this width and truncate the result back.
    localparam int MERGE_W  = 512;
    localparam int MERGE_NB = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]  old_word,
        input logic [MERGE_W-1:0]  new_word,
        input logic [MERGE_NB-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/blk_mem_array.sv
// Raw single-port synchronous storage with byte enables (read-first, registered read).
// With BLK_MEM_PARITY_EN defined, one parity bit per byte is stored alongside the data.
module blk_mem_array
    import blk_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    localparam int NB     = DATA_W / 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic [NB-1:0]     we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
`ifdef BLK_MEM_PARITY_EN
    ,
    input  logic [NB-1:0]     par_in,
    output logic [NB-1:0]     par_out
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (|we) begin
                mem[addr] <= DATA_W'(byte_merge(MERGE_W'(mem[addr]), MERGE_W'(din), MERGE_NB'(we)));
            end
            dout <= mem[addr];
        end
    end

`ifdef BLK_MEM_PARITY_EN
    logic [NB-1:0] pmem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (|we) pmem[addr] <= (pmem[addr] & ~we) | (par_in & we);
            par_out <= pmem[addr];
        end
    end
`endif

endmodule

// File: rtl/blk_mem_ctrl.sv
// Block memory controller: zero-fill FSM, range check, read-during-write modes, output stage.
// Optional per-byte parity storage and checking is enabled by defining BLK_MEM_PARITY_EN.
module blk_mem_ctrl
    import blk_mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 1024,
    parameter int OUT_REG = 0,
    parameter int WR_MODE = 0
) (
    input  logic                     clka,
    input  logic                     rsta,
    input  logic                     ena,
    input  logic [DATA_W/8-1:0]      wea,
    input  logic [$clog2(DEPTH)-1:0] addra,
    input  logic [DATA_W-1:0]        dina,
    output logic [DATA_W-1:0]        douta,
    output logic                     douta_valid,
    output logic                     busy
`ifdef BLK_MEM_PARITY_EN
    ,
    input  logic                     par_inj,
    output logic                     par_err
`endif
);

    localparam int NB     = DATA_W / 8;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [1:0]        MODE = 2'(WR_MODE);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic              in_range;
    logic              acc;
    logic              is_wr;

    logic              arr_en;
    logic [NB-1:0]     arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_din;
    logic [DATA_W-1:0] arr_dout;

    logic              v1;
    logic              oor1;
    logic              wr1;
    logic [DATA_W-1:0] din1;
    logic [NB-1:0]     we1;
    logic [DATA_W-1:0] data1;

    generate
        if ((1 << ADDR_W) == DEPTH) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_npow2
            assign in_range = addra < ADDR_W'(DEPTH);
        end
    endgenerate

    assign busy  = (state == INIT);
    assign acc   = (state == RUN) && ena;
    assign is_wr = |wea;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= RUN;
        end
    end

    // During fill the array port belongs to the counter; user accesses are ignored.
    always_comb begin
        if (state == INIT) begin
            arr_en   = 1'b1;
            arr_we   = '1;
            arr_addr = cnt;
            arr_din  = '0;
        end else begin
            arr_en   = acc && in_range;
            arr_we   = wea;
            arr_addr = addra;
            arr_din  = dina;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            v1   <= 1'b0;
            oor1 <= 1'b0;
            wr1  <= 1'b0;
            din1 <= '0;
            we1  <= '0;
        end else begin
            v1 <= acc && !(is_wr && MODE == NO_CHANGE);
            if (acc) begin
                oor1 <= !in_range;
                wr1  <= is_wr;
                din1 <= dina;
                we1  <= wea;
            end
        end
    end

    // Array is read-first; write-first data is rebuilt from the old word and the write.
    always_comb begin
        data1 = arr_dout;
        if (oor1) begin
            data1 = '0;
        end else if (wr1 && MODE == WR_FIRST) begin
            data1 = DATA_W'(byte_merge(MERGE_W'(arr_dout), MERGE_W'(din1), MERGE_NB'(we1)));
        end
    end

`ifdef BLK_MEM_PARITY_EN
    logic [NB-1:0] arr_pin;
    logic [NB-1:0] arr_pout;
    logic [NB-1:0] pin1;
    logic [NB-1:0] par_m;
    logic          err1;

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] res;
        for (int i = 0; i < NB; i++) res[i] = ^w[8*i +: 8];
        return res;
    endfunction

    assign arr_pin = (state == INIT) ? '0 : (byte_par(dina) ^ {NB{par_inj}});

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta)     pin1 <= '0;
        else if (acc) pin1 <= arr_pin;
    end

    assign par_m = (wr1 && MODE == WR_FIRST) ? ((arr_pout & ~we1) | (pin1 & we1)) : arr_pout;
    assign err1  = !oor1 && (|(byte_par(data1) ^ par_m));
`endif

    blk_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clka),
        .en     (arr_en),
        .we     (arr_we),
        .addr   (arr_addr),
        .din    (arr_din),
        .dout   (arr_dout)
`ifdef BLK_MEM_PARITY_EN
        ,
        .par_in (arr_pin),
        .par_out(arr_pout)
`endif
    );

    generate
        if (OUT_REG == 0) begin : g_direct
            logic [DATA_W-1:0] hold;
            always_ff @(posedge clka or posedge rsta) begin
                if (rsta) hold <= '0;
                else      hold <= douta;
            end
            assign douta       = v1 ? data1 : hold;
            assign douta_valid = v1;
`ifdef BLK_MEM_PARITY_EN
            assign par_err     = v1 && err1;
`endif
        end else begin : g_reg
            always_ff @(posedge clka or posedge rsta) begin
                if (rsta) begin
                    douta       <= '0;
                    douta_valid <= 1'b0;
                end else begin
                    douta_valid <= v1;
                    if (v1) douta <= data1;
                end
            end
`ifdef BLK_MEM_PARITY_EN
            always_ff @(posedge clka or posedge rsta) begin
                if (rsta) par_err <= 1'b0;
                else      par_err <= v1 && err1;
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_blk_mem_ctrl.sv
// Directed bench: three controllers share stimulus (WR_FIRST/direct, READ_FIRST/registered,
// NO_CHANGE/direct with DEPTH=1000) so every mode and depth is checked in one run.
module tb_blk_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [1:0]  wea;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic [15:0] u0_dout, u1_dout, u2_dout;
    logic        u0_vld, u1_vld, u2_vld;
    logic        u0_busy, u1_busy, u2_busy;
`ifdef BLK_MEM_PARITY_EN
    logic        par_inj;
    logic        u0_perr, u1_perr, u2_perr;
`endif

    int n_chk;
    int n_pass;

    blk_mem_ctrl #(.DATA_W(16), .DEPTH(1024), .OUT_REG(0), .WR_MODE(0)) u0 (
        .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(u0_dout), .douta_valid(u0_vld), .busy(u0_busy)
`ifdef BLK_MEM_PARITY_EN
        , .par_inj(par_inj), .par_err(u0_perr)
`endif
    );

    blk_mem_ctrl #(.DATA_W(16), .DEPTH(1024), .OUT_REG(1), .WR_MODE(1)) u1 (
        .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(u1_dout), .douta_valid(u1_vld), .busy(u1_busy)
`ifdef BLK_MEM_PARITY_EN
        , .par_inj(par_inj), .par_err(u1_perr)
`endif
    );

    blk_mem_ctrl #(.DATA_W(16), .DEPTH(1000), .OUT_REG(0), .WR_MODE(2)) u2 (
        .clka(clk), .rsta(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(u2_dout), .douta_valid(u2_vld), .busy(u2_busy)
`ifdef BLK_MEM_PARITY_EN
        , .par_inj(par_inj), .par_err(u2_perr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic e, input logic [1:0] w, input logic [9:0] a, input logic [15:0] d);
        ena   = e;
        wea   = w;
        addra = a;
        dina  = d;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 10'h0, 16'h0);
    endtask

    // Counts busy-high samples per instance from the current negedge until all are in RUN.
    task automatic wait_fill(input string tag);
        int c0, c1, c2, vb, n;
        c0 = 0; c1 = 0; c2 = 0; vb = 0; n = 0;
        while ((u0_busy || u1_busy || u2_busy) && n < 3000) begin
            if (u0_busy) begin c0++; if (u0_vld) vb++; end
            if (u1_busy) begin c1++; if (u1_vld) vb++; end
            if (u2_busy) begin c2++; if (u2_vld) vb++; end
            n++;
            tick();
        end
        chk({tag, "_busy_u0"}, 16'(c0), 16'd1024);
        chk({tag, "_busy_u1"}, 16'(c1), 16'd1024);
        chk({tag, "_busy_u2"}, 16'(c2), 16'd1000);
        chk({tag, "_vld_while_busy"}, 16'(vb), 16'd0);
    endtask

    logic [9:0]  wadr [4];
    logic [15:0] wdat [4];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        wadr = '{10'h26F, 10'h2DD, 10'h24C, 10'h2CF};
        wdat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
`ifdef BLK_MEM_PARITY_EN
        par_inj = 1'b0;
`endif
        rst = 1'b0;
        idle();
        #2 rst = 1'b1;
        tick();
        tick();
        chk("rst_dout_u0", u0_dout, 16'h0);
        chk("rst_dout_u1", u1_dout, 16'h0);
        chk("rst_vld_u0",  16'(u0_vld), 16'd0);
        chk("rst_vld_u1",  16'(u1_vld), 16'd0);
        chk("rst_busy_u0", 16'(u0_busy), 16'd1);
        chk("rst_busy_u2", 16'(u2_busy), 16'd1);

        // Zero-fill with a read held asserted throughout.
        rst = 1'b0;
        drive(1'b1, 2'b00, 10'h16F, 16'h0);
        wait_fill("fill");
        tick();
        chk("fill_rd_vld_u0", 16'(u0_vld), 16'd1);
        chk("fill_rd_u0", u0_dout, 16'h0000);
        idle();
        tick();
        chk("fill_rd_vld_u1", 16'(u1_vld), 16'd1);
        chk("fill_rd_u1", u1_dout, 16'h0000);

        // Four back-to-back writes.
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 1 && i <= 4) begin
                chk("wf_wr_u0", u0_dout, wdat[i-1]);
                chk("nc_wr_vld_u2", 16'(u2_vld), 16'd0);
            end
            if (i >= 2) begin
                chk("rf_wr_vld_u1", 16'(u1_vld), 16'd1);
                chk("rf_wr_u1", u1_dout, 16'h0000);
            end
            if (i < 4) drive(1'b1, 2'b11, wadr[i], wdat[i]);
            else       idle();
        end

        // Four back-to-back reads.
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 1 && i <= 4) begin
                chk("rd_vld_u0", 16'(u0_vld), 16'd1);
                chk("rd_u0", u0_dout, wdat[i-1]);
                chk("rd_u2", u2_dout, wdat[i-1]);
            end
            if (i >= 2) begin
                chk("rd_vld_u1", 16'(u1_vld), 16'd1);
                chk("rd_u1", u1_dout, wdat[i-2]);
            end
            if (i < 4) drive(1'b1, 2'b00, wadr[i], 16'h0);
            else       idle();
        end

        // Byte-enable partial write.
        tick(); drive(1'b1, 2'b11, 10'h1DD, 16'h1234);
        tick(); chk("be_wr1_u0", u0_dout, 16'h1234);
        drive(1'b1, 2'b01, 10'h1DD, 16'hAB55);
        tick(); chk("be_wr2_u0", u0_dout, 16'h1255);
        chk("be_wr1_u1", u1_dout, 16'h0000);
        drive(1'b1, 2'b00, 10'h1DD, 16'h0);
        tick(); chk("be_rd_u0", u0_dout, 16'h1255);
        chk("be_wr2_u1", u1_dout, 16'h1234);
        chk("be_rd_u2", u2_dout, 16'h1255);
        idle();
        tick(); chk("be_rd_u1", u1_dout, 16'h1255);

        // Read-during-write in all three modes.
        drive(1'b1, 2'b11, 10'h14C, 16'h2345);
        tick(); drive(1'b1, 2'b11, 10'h14C, 16'h7777);
        tick(); chk("rdw_wf_u0", u0_dout, 16'h7777);
        chk("rdw_nc_vld_u2", 16'(u2_vld), 16'd0);
        chk("rdw_nc_hold_u2", u2_dout, 16'h1255);
        drive(1'b1, 2'b00, 10'h14C, 16'h0);
        tick(); chk("rdw_rf_vld_u1", 16'(u1_vld), 16'd1);
        chk("rdw_rf_u1", u1_dout, 16'h2345);
        chk("rdw_rd_u0", u0_dout, 16'h7777);
        chk("rdw_rd_u2", u2_dout, 16'h7777);
        idle();
        tick(); chk("rdw_rd_u1", u1_dout, 16'h7777);

        // Address beyond DEPTH=1000 on u2; in range on the 1024-deep instances.
        drive(1'b1, 2'b11, 10'h3F0, 16'h5555);
        tick(); drive(1'b1, 2'b00, 10'h3F0, 16'h0);
        tick(); chk("oor_vld_u2", 16'(u2_vld), 16'd1);
        chk("oor_rd_u2", u2_dout, 16'h0000);
        chk("inr_rd_u0", u0_dout, 16'h5555);
        idle();
        tick(); chk("inr_rd_u1", u1_dout, 16'h5555);

        // Reset in RUN with a read in flight, then reset again mid-fill.
        drive(1'b1, 2'b11, 10'h3FF, 16'hBEEF);
        tick(); drive(1'b1, 2'b00, 10'h3FF, 16'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        idle();
        tick(); chk("mrst_vld_u0", 16'(u0_vld), 16'd0);
        chk("mrst_dout_u0", u0_dout, 16'h0000);
        chk("mrst_busy_u0", 16'(u0_busy), 16'd1);
        tick(); chk("mrst_vld_u1", 16'(u1_vld), 16'd0);
        rst = 1'b0;
        repeat (500) tick();
        rst = 1'b1;
        drive(1'b1, 2'b00, 10'h3FF, 16'h0);
        tick(); chk("frst_busy_u0", 16'(u0_busy), 16'd1);
        rst = 1'b0;
        wait_fill("refill");
        tick(); chk("refill_vld_u0", 16'(u0_vld), 16'd1);
        chk("refill_rd_u0", u0_dout, 16'h0000);
        idle();
        tick(); chk("refill_vld_u1", 16'(u1_vld), 16'd1);
        chk("refill_rd_u1", u1_dout, 16'h0000);

`ifdef BLK_MEM_PARITY_EN
        par_inj = 1'b1;
        drive(1'b1, 2'b11, 10'h2CF, 16'h8888);
        tick(); par_inj = 1'b0;
        drive(1'b1, 2'b00, 10'h2CF, 16'h0);
        tick(); chk("par_inj_err_u0", 16'(u0_perr), 16'd1);
        chk("par_inj_rd_u0", u0_dout, 16'h8888);
        drive(1'b1, 2'b11, 10'h2CF, 16'h8888);
        tick(); drive(1'b1, 2'b00, 10'h2CF, 16'h0);
        tick(); chk("par_ok_err_u0", 16'(u0_perr), 16'd0);
        chk("par_ok_vld_u0", 16'(u0_vld), 16'd1);
        idle();
        tick(); chk("par_ok_err_u1", 16'(u1_perr), 16'd0);
        chk("par_ok_err_u2", 16'(u2_perr), 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
